ad_block: RTL and testbench

- Capture-side counterpart of the DA block: drives a serial A/D converter, deserializes one DW-bit sample per conversion frame and buffers the samples in a small FIFO.
- The downstream consumer reads samples with a read-enable/valid handshake, mirroring the DA block's we/din write port in the opposite direction.
- Sits between the external ADC pins and the sample-processing datapath; single clock domain (adck).

---
 rtl/ad_block.sv | 165 ++++++++++++++++
 tb/tb_ad_block.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ad_block.sv
// ad_block: serial A/D capture front end.
// Generates cs_n/sclk framing for a serial ADC, shifts in one DW-bit sample
// per frame (MSB first) and queues samples in a first-word-fall-through FIFO
// read with a re/valid handshake. A sticky overrun flag records dropped samples.
module ad_block #(
  parameter int DW      = 8,
  parameter int DIV     = 2,
  parameter int GAP_CYC = 3,
  parameter int DEPTH   = 8,
  parameter int AW      = 3
) (
  input  logic          adck,
  input  logic          reset,
  input  logic          run,
  input  logic          re,
  input  logic          clr_ovr,
  input  logic          adc_sdata,
  output logic          adc_cs_n,
  output logic          adc_sclk,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overrun
);

  localparam int CW = $clog2(2*DIV + GAP_CYC + 1);
  localparam int BW = $clog2(DW + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] PER_LAST  = CW'(2*DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, SHIFT, DONE, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bitc;
  logic [DW-1:0] sh;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_n;
  logic [AW:0]   rem, lvl_n;
  logic          push, pop, do_push;

  // Frame sequencer: cs_n/sclk are registered and change only on state/phase edges.
  always_ff @(posedge adck or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bitc     <= '0;
      sh       <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state    <= START;
            cnt      <= '0;
            adc_cs_n <= 1'b0;
          end
        end
        START: begin
          if (cnt == PER_LAST) begin
            state <= SHIFT;
            cnt   <= '0;
            bitc  <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        SHIFT: begin
          // Sample on the same edge that raises sclk; data settled during the low half.
          if (cnt == HALF_LAST) begin
            adc_sclk <= 1'b1;
            sh       <= {sh[DW-2:0], adc_sdata};
          end
          if (cnt == PER_LAST) begin
            adc_sclk <= 1'b0;
            cnt      <= '0;
            if (bitc == BIT_LAST) begin
              state    <= DONE;
              adc_cs_n <= 1'b1;
            end else begin
              bitc <= bitc + BIT_ONE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DONE: begin
          state <= GAP;
          cnt   <= '0;
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (run) begin
              state    <= START;
              adc_cs_n <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b0;
        end
      endcase
    end
  end

  assign valid   = (level != '0);
  assign full    = (level == LVL_FULL);
  assign push    = (state == DONE);
  assign pop     = re && valid;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the sample.
  assign do_push = push && (!full || pop);

  // Next-state FIFO bookkeeping shared by the count, pointer and head logic.
  always_comb begin
    rptr_n = pop ? rptr + PTR_ONE : rptr;
    rem    = pop ? level - LVL_ONE : level;
    lvl_n  = do_push ? rem + LVL_ONE : rem;
  end

  // FIFO control, registered head (dout) and sticky overrun.
  always_ff @(posedge adck or negedge reset) begin
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      level <= lvl_n;
      rptr  <= rptr_n;
      if (do_push) wptr <= wptr + PTR_ONE;
      // Head: the incoming sample if nothing older survives, else the next stored one.
      if (lvl_n != '0) begin
        if (rem == '0) dout <= sh;
        else           dout <= mem[rptr_n];
      end
      if (push && full && !pop) overrun <= 1'b1;
      else if (clr_ovr)         overrun <= 1'b0;
    end
  end

  // Sample storage; no reset needed since level gates visibility.
  always_ff @(posedge adck) begin
    if (do_push) mem[wptr] <= sh;
  end

endmodule

// File: tb/tb_ad_block.sv
// tb_ad_block: self-checking bench for ad_block with a behavioural serial ADC
// and a queue scoreboard of samples expected to come out of the FIFO.
module tb_ad_block;

  localparam int DW = 8, DIV = 2, GAP_CYC = 3, DEPTH = 8, AW = 3;

  logic          adck = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0, re = 1'b0, clr_ovr = 1'b0, adc_sdata = 1'b0;
  logic          adc_cs_n, adc_sclk, valid, full, overrun;
  logic [DW-1:0] dout;
  logic [AW:0]   level;

  int ncmp = 0;
  int nbad = 0;

  logic [7:0] adc_q [$];   // words the ADC model will convert next
  logic [7:0] mq    [$];   // scoreboard: samples expected from the FIFO, head first
  bit         m_ovr = 0;

  ad_block #(.DW(DW), .DIV(DIV), .GAP_CYC(GAP_CYC), .DEPTH(DEPTH), .AW(AW)) dut (
    .adck(adck), .reset(reset), .run(run), .re(re), .clr_ovr(clr_ovr),
    .adc_sdata(adc_sdata), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .dout(dout), .valid(valid), .full(full), .level(level), .overrun(overrun)
  );

  always #5 adck = ~adck;

  // ADC model: loads a word when cs_n falls, presents MSB first, advances on sclk fall.
  logic [7:0] aw = '0;
  int         bi = DW - 1;
  logic       pcs = 1'b1, psclk = 1'b0;
  always @(negedge adck) begin
    if (adc_cs_n) bi = DW - 1;
    else if (pcs) begin
      aw = (adc_q.size() != 0) ? adc_q.pop_front() : 8'h00;
      bi = DW - 1;
    end else if (psclk && !adc_sclk && bi > 0) bi = bi - 1;
    adc_sdata = aw[bi];
    pcs   = adc_cs_n;
    psclk = adc_sclk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One conversion: returns cs_n low cycles and cycles waited for cs_n to fall.
  // keep_run=0 drops run mid-SHIFT; pop_done pulses re on the push edge.
  int  low_cyc, wait_cyc;
  bit  v_done;
  task automatic frame(input logic [7:0] w, input bit keep_run, input bit pop_done);
    logic [7:0] e;
    adc_q.push_back(w);
    run = 1'b1;
    low_cyc = 0; wait_cyc = 0;
    while (adc_cs_n && wait_cyc < 200) begin @(negedge adck); wait_cyc++; end
    if (adc_cs_n) chk("cs_fall_timeout", 32'(adc_cs_n), 0);
    while (!adc_cs_n && low_cyc < 200) begin
      low_cyc++;
      if (low_cyc == 10 && !keep_run) run = 1'b0;
      @(negedge adck);
    end
    if (!adc_cs_n) chk("cs_rise_timeout", 32'(adc_cs_n), 1);
    v_done = valid;
    if (pop_done) begin
      if (mq.size() == 0) chk("pop_done_model_empty", 32'(mq.size()), 1);
      else begin
        e = mq.pop_front();
        chk("pop_done_dout", 32'(dout), 32'(e));
        re = 1'b1;
      end
    end
    @(negedge adck);
    re = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(w);
    else m_ovr = 1;
  endtask

  task automatic pop_chk(input string nm);
    logic [7:0] e;
    if (mq.size() == 0) begin
      chk({nm, "_model_empty"}, 32'(mq.size()), 1);
    end else begin
      e = mq.pop_front();
      chk({nm, "_valid"}, 32'(valid), 1);
      chk({nm, "_dout"}, 32'(dout), 32'(e));
      re = 1'b1;
      @(negedge adck);
      re = 1'b0;
    end
  endtask

  task automatic chk_state(input string nm);
    chk({nm, "_level"}, 32'(level), 32'(mq.size()));
    chk({nm, "_valid"}, 32'(valid), 32'(mq.size() != 0));
    chk({nm, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({nm, "_ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  typedef struct {
    logic [7:0] d;
    int         lvl;
    bit         fl;
    bit         ov;
  } vec_t;

  initial begin
    vec_t tbl [9];
    int   hi;
    for (int i = 0; i < 9; i++) begin
      tbl[i].d   = 8'(4 + i);
      tbl[i].lvl = (i < 8) ? i + 1 : 8;
      tbl[i].fl  = (i >= 7);
      tbl[i].ov  = (i == 8);
    end

    // Reset values
    repeat (3) @(negedge adck);
    chk("rst_cs_n", 32'(adc_cs_n), 1);
    chk("rst_sclk", 32'(adc_sclk), 0);
    chk("rst_dout", 32'(dout), 0);
    chk_state("rst");
    reset = 1'b1;
    @(negedge adck);

    // Single frame 0xA5: 36 cycles of cs_n low, valid one cycle after DONE
    frame(8'hA5, 0, 0);
    chk("a5_cs_low", 32'(low_cyc), 36);
    chk("a5_valid_at_done", 32'(v_done), 0);
    chk("a5_dout", 32'(dout), 32'hA5);
    chk_state("a5");
    pop_chk("a5_pop");

    // Back-to-back frames 1,2,3
    frame(8'h01, 1, 0);
    frame(8'h02, 1, 0);
    chk("gap_cycles", 32'(wait_cyc), GAP_CYC);
    frame(8'h03, 0, 0);
    chk_state("three");
    chk("three_head", 32'(dout), 1);
    for (int i = 0; i < 3; i++) pop_chk("three_pop");
    chk_state("three_empty");
    chk("hold_dout", 32'(dout), 3);
    re = 1'b1; @(negedge adck); re = 1'b0;
    chk_state("underflow");

    // Table: fill past full, 9th sample dropped
    for (int i = 0; i < 9; i++) begin
      frame(tbl[i].d, 0, 0);
      chk("tbl_level", 32'(level), 32'(tbl[i].lvl));
      chk("tbl_full", 32'(full), 32'(tbl[i].fl));
      chk("tbl_ovr", 32'(overrun), 32'(tbl[i].ov));
    end
    for (int i = 0; i < 8; i++) pop_chk("ovr_pop");
    chk("ovr_sticky", 32'(overrun), 1);
    clr_ovr = 1'b1; @(negedge adck); clr_ovr = 1'b0;
    m_ovr = 0;
    chk("ovr_cleared", 32'(overrun), 0);

    // Full FIFO with pop on the push edge: no drop, new sample at tail
    for (int i = 0; i < 8; i++) frame(8'(20 + i), 0, 0);
    chk_state("full8");
    frame(8'd28, 0, 1);
    chk_state("pop_on_done");
    for (int i = 0; i < 8; i++) pop_chk("tail_pop");
    chk_state("tail_empty");

    // run dropped mid-SHIFT: frame completes, then stays idle
    frame(8'h5A, 0, 0);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge adck);
      if (!adc_cs_n) hi++;
    end
    chk("idle_cs_low_cycles", 32'(hi), 0);
    pop_chk("run_drop_pop");

    // Reset mid-SHIFT with level 2
    frame(8'h55, 0, 0);
    frame(8'h66, 0, 0);
    chk("pre_rst_level", 32'(level), 2);
    adc_q.push_back(8'h77);
    run = 1'b1;
    hi = 0;
    while (adc_cs_n && hi < 200) begin @(negedge adck); hi++; end
    repeat (10) @(negedge adck);
    reset = 1'b0;
    #1;
    chk("mid_rst_cs_n", 32'(adc_cs_n), 1);
    chk("mid_rst_sclk", 32'(adc_sclk), 0);
    chk("mid_rst_dout", 32'(dout), 0);
    mq.delete();
    m_ovr = 0;
    chk_state("mid_rst");
    run = 1'b0;
    @(negedge adck);
    reset = 1'b1;
    frame(8'h3C, 0, 0);
    chk_state("post_rst");
    pop_chk("post_rst_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
